// File: rtl/sign_div.sv
// Sequential signed divider: sign-magnitude front end, restoring shift-subtract
// core producing one quotient bit per cycle, then sign correction and overrides.
module sign_div #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
  localparam logic [CW-1:0]      LAST_BIT = CW'(WIDTH_N - 1);
  localparam logic [WIDTH_N-1:0] MOST_NEG = {1'b1, {(WIDTH_N-1){1'b0}}};
  localparam logic [WIDTH_N-1:0] MAX_POS  = {1'b0, {(WIDTH_N-1){1'b1}}};

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               sn, sd;
  logic [WIDTH_N-1:0] raw_n;
  logic [WIDTH_D-1:0] raw_d;
  logic [WIDTH_N-1:0] qsh;
  logic [WIDTH_D-1:0] mag_d;
  logic [WIDTH_D:0]   prem;
  logic [WIDTH_D:0]   trial;
  logic               take;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // qsh starts as |dividend| and is shifted out MSB-first while quotient bits
  // enter at the LSB, so after WIDTH_N iterations it holds the magnitude quotient.
  assign trial = {prem[WIDTH_D-1:0], qsh[WIDTH_N-1]};
  assign take  = (trial >= {1'b0, mag_d});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)          state_nx = CALC;
      CALC: if (cnt == LAST_BIT)   state_nx = FIX;
      FIX:                         state_nx = DONE;
      DONE: if (out_ready)         state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sn          <= 1'b0;
      sd          <= 1'b0;
      raw_n       <= '0;
      raw_d       <= '0;
      qsh         <= '0;
      mag_d       <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sn          <= dividend[WIDTH_N-1];
          sd          <= divisor[WIDTH_D-1];
          raw_n       <= dividend;
          raw_d       <= divisor;
          qsh         <= dividend[WIDTH_N-1] ? -dividend : dividend;
          mag_d       <= divisor[WIDTH_D-1] ? -divisor : divisor;
          prem        <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
        CALC: begin
          prem <= take ? (trial - {1'b0, mag_d}) : trial;
          qsh  <= {qsh[WIDTH_N-2:0], take};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          if (raw_d == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end else if (raw_n == MOST_NEG && raw_d == '1) begin
            quotient  <= MAX_POS;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= (sn ^ sd) ? -qsh : qsh;
            remainder <= sn ? -prem[WIDTH_D-1:0] : prem[WIDTH_D-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_div.sv
// Randomised scoreboard bench for sign_div: a driver pushes reference results,
// a negedge monitor compares whenever the divider presents a result.
module tb_sign_div;
  localparam int WN = 16;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [WN-1:0] dividend = '0;
  logic [WD-1:0] divisor = '0;
  logic          in_ready, out_valid, div_by_zero, overflow;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;

  sign_div #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dz;
    logic          ov;
    int            acc;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            last_hs = 0;
  int            last_acc = 0;
  logic          prev_v = 1'b0;
  logic [WN-1:0] last_q = '0;
  logic [WD-1:0] last_r = '0;
  bit            have_last = 1'b0;
  bit            rnd_ready = 1'b0;
  bit            force_ready = 1'b1;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: plain integer division (truncating) with the two special cases.
  function automatic exp_t model(input logic [WN-1:0] a, input logic [WD-1:0] b);
    exp_t e;
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.acc = 0;
    if (sb == 0) begin
      e.q = '1;
      e.r = '0;
      e.dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      if (q > (2 ** (WN - 1)) - 1) begin
        e.q = {1'b0, {(WN-1){1'b1}}};
        e.r = '0;
        e.ov = 1'b1;
      end else begin
        e.q = WN'(q);
        e.r = WD'(r);
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [WN-1:0] a, input logic [WD-1:0] b);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    e = model(a, b);
    e.acc = cyc + 1;
    last_acc = e.acc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = WN'($urandom);
    divisor  = WD'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!prev_v) chk("latency", 32'(cyc - sbq[0].acc), 32'(WN + 1));
          chk("quotient", 32'(quotient), 32'(sbq[0].q));
          chk("remainder", 32'(remainder), 32'(sbq[0].r));
          chk("div_by_zero", 32'(div_by_zero), 32'(sbq[0].dz));
          chk("overflow", 32'(overflow), 32'(sbq[0].ov));
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          if (out_ready) begin
            last_q = sbq[0].q;
            last_r = sbq[0].r;
            have_last = 1'b1;
            last_hs = cyc + 1;
            void'(sbq.pop_front());
          end
        end
      end else if (have_last) begin
        chk("quotient_hold", 32'(quotient), 32'(last_q));
        chk("remainder_hold", 32'(remainder), 32'(last_r));
      end
      prev_v = out_valid;
    end
  end

  int dir_a[12] = '{100, -100, 100, -100, -32768, -32768, 5, 6, -32768, 32767, 0, -1};
  int dir_b[12] = '{7, 7, -7, -7, -128, -1, 0, 3, 1, -1, -128, 127};

  initial begin
    logic [WN-1:0] a;
    logic [WD-1:0] b;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    last_q = '0;
    last_r = '0;
    have_last = 1'b1;

    for (int i = 0; i < 12; i++) issue(WN'(dir_a[i]), WD'(dir_b[i]));
    drain();

    // Stalled consumer: second operand must wait for the output handshake.
    force_ready = 1'b0;
    fork
      begin
        issue(WN'(1234), WD'(-9));
        issue(WN'(-4321), WD'(13));
      end
      begin
        t = 0;
        while (!out_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        chk("stall_valid_timeout", 32'(out_valid), 32'd1);
        repeat (10) @(negedge clk);
        force_ready = 1'b1;
      end
    join
    chk("accept_after_handshake", 32'(last_acc), 32'(last_hs + 1));
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = WN'($urandom);
      b = WD'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: a = {1'b1, {(WN-1){1'b0}}};
        3: begin a = {1'b1, {(WN-1){1'b0}}}; b = '1; end
        default: ;
      endcase
      issue(a, b);
    end
    drain();
    rnd_ready = 1'b0;
    force_ready = 1'b1;

    // Abort mid-calculation.
    issue(WN'(1000), WD'(3));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
    sbq.delete();
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(WN'(1000), WD'(3));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
